// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter
//   Owns the four general registers r0..r3 and shares their single access
//   port among NREQ requesters with round-robin arbitration. At most one
//   read or write is granted per cycle; read data comes back one cycle after
//   the grant. A requester may hold the port for a short read-modify-write
//   sequence (lock), bounded by LOCK_MAX consecutive granted cycles.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   req     per-requester access request, held until granted
//   we      per-requester write enable (1 = write, 0 = read)
//   lock    per-requester request to keep the grant next cycle
//   addr    per-requester register index, requester i uses [2i+1:2i]
//   wdata   per-requester write data, requester i uses slice i
//   gnt     one-hot grant, combinational, same cycle as the access
//   sel     register select code of the granted access, 0 when idle
//   rdata   registered read data
//   rvalid  one-hot owner of rdata, high one cycle after a granted read
//   r0..r3  register contents
module reg_port_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 3,
  parameter int LOCK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ-1:0]         lock,
  input  logic [2*NREQ-1:0]       addr,
  input  logic [WIDTH*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [1:0]              sel,
  output logic [WIDTH-1:0]        rdata,
  output logic [NREQ-1:0]         rvalid,
  output logic [WIDTH-1:0]        r0,
  output logic [WIDTH-1:0]        r1,
  output logic [WIDTH-1:0]        r2,
  output logic [WIDTH-1:0]        r3
);

  logic [WIDTH-1:0] regs_r [4];
  logic [WIDTH-1:0] rdata_r;
  logic [NREQ-1:0]  rvalid_r;
  logic [1:0]       ptr_r;
  logic             own_vld_r;
  logic [1:0]       own_r;
  logic [3:0]       cnt_r;

  logic             own_req_s;
  logic             gany_s;
  logic             locked_gnt_s;
  logic [1:0]       gidx_s;
  logic [NREQ-1:0]  gnt_s;
  logic [1:0]       g_addr_s;
  logic             g_we_s;
  logic             g_lock_s;
  logic [WIDTH-1:0] g_wdata_s;
  logic [1:0]       ptr_next_s;
  logic             own_vld_next_s;
  logic [1:0]       own_next_s;
  logic [3:0]       cnt_next_s;
  logic [3:0]       cnt_inc_s;
  logic [1:0]       gidx_inc_s;
  int               idx_s;

  // Whether the current lock owner is still requesting.
  always_comb begin
    own_req_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_r == 2'(i)) begin
        own_req_s = req[i];
      end else begin
        own_req_s = own_req_s;
      end
    end
  end

  // Grant selection: live lock owner first, else round-robin from the pointer.
  always_comb begin
    gany_s       = 1'b0;
    locked_gnt_s = 1'b0;
    gidx_s       = 2'd0;
    idx_s        = 0;
    if (rst_n == 1'b0) begin
      gany_s = 1'b0;
    end else if (own_vld_r && own_req_s) begin
      gany_s       = 1'b1;
      locked_gnt_s = 1'b1;
      gidx_s       = own_r;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = (int'(ptr_r) + k) % NREQ;
        if (!gany_s && req[idx_s]) begin
          gany_s = 1'b1;
          gidx_s = idx_s[1:0];
        end else begin
          gany_s = gany_s;
        end
      end
    end
  end

  // One-hot grant and mux of the granted requester's access fields.
  always_comb begin
    gnt_s     = '0;
    g_addr_s  = 2'd0;
    g_we_s    = 1'b0;
    g_lock_s  = 1'b0;
    g_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gany_s && (gidx_s == 2'(i))) begin
        gnt_s[i]  = 1'b1;
        g_addr_s  = addr[2*i +: 2];
        g_we_s    = we[i];
        g_lock_s  = lock[i];
        g_wdata_s = wdata[WIDTH*i +: WIDTH];
      end else begin
        gnt_s[i] = 1'b0;
      end
    end
  end

  assign cnt_inc_s  = cnt_r + 4'd1;
  assign gidx_inc_s = (gidx_s == 2'(NREQ - 1)) ? 2'd0 : (gidx_s + 2'd1);

  // Pointer and lock bookkeeping for the next cycle.
  always_comb begin
    ptr_next_s     = ptr_r;
    own_vld_next_s = own_vld_r;
    own_next_s     = own_r;
    cnt_next_s     = cnt_r;
    if (gany_s && locked_gnt_s) begin
      // Pointer already sits past the owner since it acquired the lock.
      if (cnt_inc_s >= 4'(LOCK_MAX)) begin
        own_vld_next_s = 1'b0;
        cnt_next_s     = 4'd0;
        ptr_next_s     = gidx_inc_s;
      end else if (!g_lock_s) begin
        own_vld_next_s = 1'b0;
        cnt_next_s     = 4'd0;
      end else begin
        cnt_next_s = cnt_inc_s;
      end
    end else if (gany_s) begin
      ptr_next_s = gidx_inc_s;
      if (g_lock_s && (LOCK_MAX > 1)) begin
        own_vld_next_s = 1'b1;
        own_next_s     = gidx_s;
        cnt_next_s     = 4'd1;
      end else begin
        own_vld_next_s = 1'b0;
        cnt_next_s     = 4'd0;
      end
    end else begin
      // Owner dropped its request with nobody else asking: release.
      own_vld_next_s = 1'b0;
      cnt_next_s     = 4'd0;
    end
  end

  // Register file, read data and read-valid tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= '0;
      end
      rdata_r  <= '0;
      rvalid_r <= '0;
    end else if (gany_s && g_we_s) begin
      regs_r[g_addr_s] <= g_wdata_s;
      rvalid_r         <= '0;
    end else if (gany_s) begin
      rdata_r  <= regs_r[g_addr_s];
      rvalid_r <= gnt_s;
    end else begin
      rvalid_r <= '0;
    end
  end

  // Arbitration state: round-robin pointer and lock owner/counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= 2'd0;
      own_vld_r <= 1'b0;
      own_r     <= 2'd0;
      cnt_r     <= 4'd0;
    end else begin
      ptr_r     <= ptr_next_s;
      own_vld_r <= own_vld_next_s;
      own_r     <= own_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  assign gnt    = gnt_s;
  assign sel    = g_addr_s;
  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign r0     = regs_r[0];
  assign r1     = regs_r[1];
  assign r2     = regs_r[2];
  assign r3     = regs_r[3];

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Owns the four general registers r0..r3 and shares their single access port among NREQ requesters, e.g. fetch/decode, ALU writeback and debug.
- Each cycle it grants at most one read or write using round-robin arbitration.
- Read data is registered and returned one cycle after the grant.
- Exports r0..r3 and the current select code so the existing 4:1 register select logic can be driven directly.
- A requester may lock the port for a short read-modify-write sequence, bounded by a timeout.

Parameters:
- WIDTH, 8, register data width.
- NREQ, 3, number of requesters (2..4).
- LOCK_MAX, 4, maximum consecutive granted cycles while locked (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request; held until granted.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- lock  in  NREQ  per-requester request to keep the grant next cycle.
- addr  in  2*NREQ  per-requester register index; requester i uses bits [2i+1:2i].
- wdata  in  WIDTH*NREQ  per-requester write data; requester i uses slice i.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the access.
- sel  out  2  address of the granted access (register select code); 0 when idle.
- rdata  out  WIDTH  registered read data.
- rvalid  out  NREQ  one-hot, high one cycle after a granted read, identifying the owner of rdata.
- r0  out  WIDTH  register 0 contents.
- r1  out  WIDTH  register 1 contents.
- r2  out  WIDTH  register 2 contents.
- r3  out  WIDTH  register 3 contents.

Behaviour:
- Reset (async, rst_n=0):
  - r0..r3 = 0, rdata = 0, rvalid = 0.
  - Round-robin pointer = 0 (requester 0 has top priority).
  - Lock owner cleared, lock counter = 0.
  - gnt = 0 and sel = 0 while in reset.
  - Reset asserted mid-lock or mid-read drops the lock and discards any pending rvalid.
- Arbitration (combinational):
  - If a lock owner exists and its req=1, gnt = owner.
  - Otherwise gnt = first requester with req=1, scanning from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - No req: gnt = 0 and no state change except rvalid clearing.
- Access at the clock edge when gnt[i]=1:
  - we[i]=1: register addr_i <= wdata_i; rvalid next = 0.
  - we[i]=0: rdata <= register addr_i; rvalid next = one-hot i.
  - rdata holds its value when no read is granted.
- Pointer update: after any grant to i, pointer <= (i+1) mod NREQ. It is not updated on cycles granted through an active lock.
- Lock:
  - A grant to i with lock[i]=1 makes i the owner; the counter increments on each granted cycle.
  - The lock is released when lock[i]=0, when req[i]=0, or when the counter reaches LOCK_MAX.
  - On timeout the pointer advances past i and the counter resets, so the cycle after LOCK_MAX grants goes to another requester if one is waiting.
- Ordering and hazards:
  - One access per cycle, so there are no write/write or read/write collisions.
  - A read granted in the cycle after a write to the same register returns the new value.
  - r0..r3 update at the same edge as the write.
- Out-of-range index: none; the 2-bit address always maps to r0..r3.
- Latency: write visible 1 edge after grant; read data and rvalid 1 edge after grant.

Test Plan:
- Reset, then requester 0 writes 0xA5 to r2 -> gnt=001 that cycle, sel=2; r2=0xA5 after the edge; rvalid stays 0.
- Requesters 0, 1 and 2 all hold read requests continuously after reset -> grants go 0, 1, 2, 0 in successive cycles; rvalid follows one cycle behind with the matching one-hot value.
- Requester 1 writes 0x3C to r1, then reads r1 on the next cycle -> rdata=0x3C with rvalid=010 one cycle after the read grant.
- Requester 2 locks with LOCK_MAX=4 while requester 0 requests continuously -> gnt=100 for exactly 4 cycles, then 001; pointer is 0 afterwards.
- rst_n pulsed low during a locked read with r0..r3 non-zero -> all registers=0, rvalid=0, and the next grant goes to requester 0 when all requesters request.
